// File: rtl/camera_pkg.sv
// camera_pkg: shared types and constants for the camera pixel packer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, pixel/word geometry, buffered word struct.
package camera_pkg;

  localparam int PIXEL_WIDTH     = 16;
  localparam int PIXELS_PER_WORD = 8;
  localparam int WORD_WIDTH      = PIXEL_WIDTH * PIXELS_PER_WORD;
  localparam int H_ACTIVE        = 1280;
  localparam int V_ACTIVE        = 720;
  localparam int FRAME_WORDS     = (H_ACTIVE * V_ACTIVE) / PIXELS_PER_WORD;
  localparam int WC_WIDTH        = 17;
  localparam int LANE_WIDTH      = 3;
  localparam int HCOUNT_WIDTH    = 11;
  localparam int VCOUNT_WIDTH    = 10;

  typedef enum logic {
    SEEK = 1'b0,
    PACK = 1'b1
  } state_t;

  // One buffered output beat: packed pixels plus end-of-frame marker.
  typedef struct packed {
    logic                  tlast;
    logic [WORD_WIDTH-1:0] data;
  } word_t;

endpackage

// File: rtl/evt_counter.sv
// evt_counter: wrapping event counter, counts 0..MAX_COUNT-1 then wraps to 0.
// Latency: count updates on the edge where i_inc is sampled; o_at_max is combinational.
// Backpressure: none; i_clr has priority over i_inc.
// Ports: i_clk, i_rst_n (async active-low), i_clr, i_inc, o_count, o_at_max.
module evt_counter #(
  parameter int MAX_COUNT = 115200,
  parameter int WIDTH     = 17
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count,
  output logic             o_at_max
);

  logic [WIDTH-1:0] r_count;

  assign o_count  = r_count;
  assign o_at_max = (r_count == WIDTH'(MAX_COUNT - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= o_at_max ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/skid_fifo2.sv
// skid_fifo2: two-entry valid/ready buffer; head entry drives the output directly.
// Latency: 1 cycle from push to o_pop_vld.
// Backpressure: o_push_rdy low only when full and not popping; push+pop on full is accepted.
// Ports: i_clk, i_rst_n, i_push_vld/i_push_dat/o_push_rdy, o_pop_vld/o_pop_dat/i_pop_rdy.
module skid_fifo2 #(
  parameter int WIDTH = 129
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push_vld,
  input  logic [WIDTH-1:0] i_push_dat,
  output logic             o_push_rdy,
  output logic             o_pop_vld,
  output logic [WIDTH-1:0] o_pop_dat,
  input  logic             i_pop_rdy
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wp;
  logic             r_rp;
  logic [1:0]       r_cnt;
  logic             w_pop;
  logic             w_push;

  assign o_pop_vld  = (r_cnt != 2'd0);
  assign o_pop_dat  = r_mem[r_rp];
  assign w_pop      = i_pop_rdy && o_pop_vld;
  // When full, the slot being written is the head that leaves this same cycle.
  assign o_push_rdy = (r_cnt != 2'd2) || w_pop;
  assign w_push     = i_push_vld && o_push_rdy;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_push_dat;
        r_wp        <= ~r_wp;
      end
      if (w_pop) begin
        r_rp <= ~r_rp;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/camera_pixel_packer.sv
// camera_pixel_packer: packs 16-bit pixels into 128-bit AXI-Stream words aligned to frame start.
// Latency: word valid 1 cycle after the edge accepting its 8th pixel.
// Backpressure: 2-word buffer; a word completing while full is dropped (sticky overflow, resync to next frame).
// Ports: clk_in, rst_in (async active-low), pixel_valid_in/pixel_data_in/hcount_in/vcount_in,
//        write_axis_data/valid/tlast/ready, overflow_out, resync_out, frame_done_out.
module camera_pixel_packer
  import camera_pkg::*;
#(
  parameter int N_FRAME_WORDS = FRAME_WORDS
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    pixel_valid_in,
  input  logic [PIXEL_WIDTH-1:0]  pixel_data_in,
  input  logic [HCOUNT_WIDTH-1:0] hcount_in,
  input  logic [VCOUNT_WIDTH-1:0] vcount_in,
  output logic [WORD_WIDTH-1:0]   write_axis_data,
  output logic                    write_axis_valid,
  output logic                    write_axis_tlast,
  input  logic                    write_axis_ready,
  output logic                    overflow_out,
  output logic                    resync_out,
  output logic                    frame_done_out
);

  state_t                                    r_state;
  state_t                                    w_state_nxt;
  logic [LANE_WIDTH-1:0]                     r_lane;
  logic [LANE_WIDTH-1:0]                     w_lane_nxt;
  logic [LANE_WIDTH-1:0]                     w_wr_lane;
  logic [PIXELS_PER_WORD-1:0][PIXEL_WIDTH-1:0] r_pix;
  logic                                      r_overflow;
  logic                                      r_resync;
  logic                                      r_frame_done;

  logic                                      w_sof;
  logic                                      w_store;
  logic                                      w_word_done;
  logic                                      w_wc_clr;
  logic                                      w_wc_inc;
  logic                                      w_resync;
  logic                                      w_ovf_evt;
  logic [WC_WIDTH-1:0]                       w_wc;
  logic                                      w_wc_last;
  word_t                                     w_push_word;
  word_t                                     w_head;
  logic                                      w_push_rdy;
  logic                                      w_pop_vld;
  logic                                      w_pop;

  assign w_sof = pixel_valid_in && (hcount_in == '0) && (vcount_in == '0);
  assign w_pop = w_pop_vld && write_axis_ready;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= SEEK;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_lane_nxt  = r_lane;
    w_wr_lane   = r_lane;
    w_store     = 1'b0;
    w_word_done = 1'b0;
    w_wc_clr    = 1'b0;
    w_wc_inc    = 1'b0;
    w_resync    = 1'b0;
    w_ovf_evt   = 1'b0;
    case (r_state)
      SEEK: begin
        if (w_sof) begin
          w_store     = 1'b1;
          w_wr_lane   = '0;
          w_lane_nxt  = LANE_WIDTH'(1);
          w_wc_clr    = 1'b1;
          w_state_nxt = PACK;
        end
      end
      PACK: begin
        if (pixel_valid_in) begin
          w_store = 1'b1;
          if (w_sof && ((r_lane != '0) || (w_wc != '0))) begin
            // Early frame start: abandon the partial frame, restart on this pixel.
            w_resync   = 1'b1;
            w_wr_lane  = '0;
            w_lane_nxt = LANE_WIDTH'(1);
            w_wc_clr   = 1'b1;
          end else if (r_lane == LANE_WIDTH'(PIXELS_PER_WORD - 1)) begin
            w_word_done = 1'b1;
            w_lane_nxt  = '0;
            if (w_push_rdy) begin
              w_wc_inc = 1'b1;
            end else begin
              // Buffer full and not draining: drop the word and realign.
              w_ovf_evt   = 1'b1;
              w_resync    = 1'b1;
              w_state_nxt = SEEK;
            end
          end else begin
            w_lane_nxt = r_lane + LANE_WIDTH'(1);
          end
        end
      end
      default: w_state_nxt = SEEK;
    endcase
  end

  // Completed word: lanes 0..6 from registers, lane 7 is the pixel arriving now.
  always_comb begin
    w_push_word.data = r_pix;
    w_push_word.data[WORD_WIDTH-1 -: PIXEL_WIDTH] = pixel_data_in;
    w_push_word.tlast = w_wc_last;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_lane       <= '0;
      r_pix        <= '0;
      r_overflow   <= 1'b0;
      r_resync     <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_lane <= w_lane_nxt;
      if (w_store) begin
        r_pix[w_wr_lane] <= pixel_data_in;
      end
      r_overflow   <= r_overflow | w_ovf_evt;
      r_resync     <= w_resync;
      r_frame_done <= w_pop && w_head.tlast;
    end
  end

  evt_counter #(
    .MAX_COUNT (N_FRAME_WORDS),
    .WIDTH     (WC_WIDTH)
  ) u_word_cnt (
    .i_clk    (clk_in),
    .i_rst_n  (rst_in),
    .i_clr    (w_wc_clr),
    .i_inc    (w_wc_inc),
    .o_count  (w_wc),
    .o_at_max (w_wc_last)
  );

  skid_fifo2 #(
    .WIDTH ($bits(word_t))
  ) u_out_buf (
    .i_clk      (clk_in),
    .i_rst_n    (rst_in),
    .i_push_vld (w_word_done),
    .i_push_dat (w_push_word),
    .o_push_rdy (w_push_rdy),
    .o_pop_vld  (w_pop_vld),
    .o_pop_dat  (w_head),
    .i_pop_rdy  (write_axis_ready)
  );

  assign write_axis_valid = w_pop_vld;
  assign write_axis_data  = w_head.data;
  assign write_axis_tlast = w_head.tlast & w_pop_vld;
  assign overflow_out     = r_overflow;
  assign resync_out       = r_resync;
  assign frame_done_out   = r_frame_done;

endmodule

// File: tb/tb_camera_pixel_packer.sv
// tb_camera_pixel_packer: self-checking bench for camera_pixel_packer on a reduced 32x4 frame.
// Latency: n/a.
// Backpressure: ready driven per scenario (held low, high, random).
module tb_camera_pixel_packer;

  localparam int H  = 32;
  localparam int V  = 4;
  localparam int FW = (H * V) / 8;

  logic         clk_in = 1'b0;
  logic         rst_in = 1'b1;
  logic         pixel_valid_in = 1'b0;
  logic [15:0]  pixel_data_in = '0;
  logic [10:0]  hcount_in = '0;
  logic [9:0]   vcount_in = '0;
  logic         write_axis_ready = 1'b0;
  logic [127:0] write_axis_data;
  logic         write_axis_valid;
  logic         write_axis_tlast;
  logic         overflow_out;
  logic         resync_out;
  logic         frame_done_out;

  int n_tests = 0;
  int n_fail  = 0;
  int pos_h   = 0;
  int pos_v   = 0;

  camera_pixel_packer #(.N_FRAME_WORDS(FW)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .pixel_valid_in   (pixel_valid_in),
    .pixel_data_in    (pixel_data_in),
    .hcount_in        (hcount_in),
    .vcount_in        (vcount_in),
    .write_axis_data  (write_axis_data),
    .write_axis_valid (write_axis_valid),
    .write_axis_tlast (write_axis_tlast),
    .write_axis_ready (write_axis_ready),
    .overflow_out     (overflow_out),
    .resync_out       (resync_out),
    .frame_done_out   (frame_done_out)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: pixels gathered into a word by count, finished words
  // queued (at most two outstanding), frame position tracked as a word index.
  bit           m_aligned = 0;
  int           m_npix = 0;
  int           m_wc = 0;
  logic [127:0] m_word = '0;
  logic [128:0] m_q[$];
  bit           m_ovf = 0;
  bit           m_resync = 0;
  bit           m_done = 0;

  always @(posedge clk_in or negedge rst_in) begin
    int  sz;
    bit  pop;
    bit  room;
    bit  sof;
    if (!rst_in) begin
      m_aligned = 0; m_npix = 0; m_wc = 0; m_word = '0;
      m_ovf = 0; m_resync = 0; m_done = 0;
      m_q.delete();
    end else begin
      sz   = m_q.size();
      pop  = (sz > 0) && write_axis_ready;
      room = (sz < 2) || pop;
      m_done   = 0;
      m_resync = 0;
      if (pop) begin
        m_done = m_q[0][128];
        void'(m_q.pop_front());
      end
      sof = (hcount_in == 0) && (vcount_in == 0);
      if (pixel_valid_in) begin
        if (!m_aligned) begin
          if (sof) begin
            m_aligned = 1; m_npix = 1; m_wc = 0; m_word[15:0] = pixel_data_in;
          end
        end else if (sof && (m_npix != 0 || m_wc != 0)) begin
          m_resync = 1; m_npix = 1; m_wc = 0; m_word[15:0] = pixel_data_in;
        end else begin
          m_word[m_npix*16 +: 16] = pixel_data_in;
          m_npix++;
          if (m_npix == 8) begin
            m_npix = 0;
            if (room) begin
              m_q.push_back({(m_wc == FW - 1), m_word});
              m_wc = (m_wc + 1) % FW;
            end else begin
              m_ovf = 1; m_resync = 1; m_aligned = 0;
            end
          end
        end
      end
    end
  end

  // Handshake monitor: everything the sink actually accepted.
  logic [128:0] rx_q[$];
  int           done_cnt = 0;
  int           resync_cnt = 0;

  always @(posedge clk_in) begin
    if (rst_in && write_axis_valid && write_axis_ready)
      rx_q.push_back({write_axis_tlast, write_axis_data});
    if (frame_done_out) done_cnt++;
    if (resync_out) resync_cnt++;
  end

  function automatic logic [132:0] exp_vec();
    logic [128:0] hd = '0;
    if (m_q.size() > 0) hd = m_q[0];
    return {(m_q.size() > 0), hd, m_ovf, m_resync, m_done};
  endfunction

  function automatic logic [132:0] dut_vec();
    return {write_axis_valid, (write_axis_valid ? {write_axis_tlast, write_axis_data} : 129'd0),
            overflow_out, resync_out, frame_done_out};
  endfunction

  // Word k of a frame whose pixel value is its linear index.
  function automatic logic [128:0] lin_word(input int k, input bit last);
    logic [128:0] w;
    w[128] = last;
    for (int j = 0; j < 8; j++) w[16*j +: 16] = 16'(8 * k + j);
    return w;
  endfunction

  function automatic logic [15:0] cur_lin();
    return 16'(pos_v * H + pos_h);
  endfunction

  task automatic tick(input bit pv, input bit rdy, input logic [15:0] d);
    pixel_valid_in   = pv;
    pixel_data_in    = d;
    hcount_in        = 11'(pos_h);
    vcount_in        = 10'(pos_v);
    write_axis_ready = rdy;
    @(negedge clk_in);
    if (pv) begin
      pos_h++;
      if (pos_h == H) begin
        pos_h = 0;
        pos_v++;
        if (pos_v == V) pos_v = 0;
      end
    end
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    pixel_valid_in = 1'b0;
    write_axis_ready = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    pos_h = 0;
    pos_v = 0;
  endtask

  task automatic test_reset();
    @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    n_tests++; if (write_axis_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", write_axis_valid); end
    n_tests++; if (write_axis_data !== 128'd0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", write_axis_data); end
    n_tests++; if (write_axis_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast got=%b exp=0", write_axis_tlast); end
    n_tests++; if (overflow_out !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", overflow_out); end
    n_tests++; if (resync_out !== 1'b0) begin n_fail++; $display("FAIL reset_resync got=%b exp=0", resync_out); end
    n_tests++; if (frame_done_out !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got=%b exp=0", frame_done_out); end
    rst_in = 1'b1;
    @(negedge clk_in);
    n_tests++; if (write_axis_valid !== 1'b0) begin n_fail++; $display("FAIL reset_release_valid got=%b exp=0", write_axis_valid); end
  endtask

  task automatic test_full_frame();
    int base, d0;
    logic [127:0] w0;
    do_reset();
    base = rx_q.size();
    d0   = done_cnt;
    w0   = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
    for (int i = 0; i < H * V + 4; i++) begin
      if (i < H * V) tick(1'b1, 1'b1, cur_lin());
      else           tick(1'b0, 1'b1, 16'd0);
      n_tests++;
      if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL full_frame_cycle t=%0t got=%h exp=%h", $time, dut_vec(), exp_vec()); end
    end
    n_tests++;
    if (rx_q.size() - base !== FW) begin n_fail++; $display("FAIL full_frame_count got=%0d exp=%0d", rx_q.size() - base, FW); end
    else begin
      n_tests++; if (rx_q[base][127:0] !== w0) begin n_fail++; $display("FAIL full_frame_word0 got=%h exp=%h", rx_q[base][127:0], w0); end
      for (int k = 0; k < FW; k++) begin
        n_tests++;
        if (rx_q[base + k] !== lin_word(k, k == FW - 1)) begin n_fail++; $display("FAIL full_frame_word%0d got=%h exp=%h", k, rx_q[base + k], lin_word(k, k == FW - 1)); end
      end
    end
    n_tests++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL full_frame_done got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_mid_start();
    int base, npost, remaining;
    logic [15:0]  d;
    logic [127:0] expw;
    do_reset();
    pos_h = 13;
    pos_v = 2;
    base  = rx_q.size();
    npost = 0;
    expw  = '0;
    remaining = H * V - (pos_v * H + pos_h);
    for (int i = 0; i < remaining + 8; i++) begin
      d = 16'($urandom);
      if (i == remaining) begin
        n_tests++;
        if (rx_q.size() !== base || write_axis_valid !== 1'b0) begin n_fail++; $display("FAIL mid_start_early_out got=%0d words exp=0", rx_q.size() - base); end
      end
      if (i >= remaining) begin expw[16*npost +: 16] = d; npost++; end
      tick(1'b1, 1'b1, d);
      n_tests++;
      if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL mid_start_cycle t=%0t got=%h exp=%h", $time, dut_vec(), exp_vec()); end
    end
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 16'd0);
    n_tests++;
    if (rx_q.size() - base !== 1) begin n_fail++; $display("FAIL mid_start_count got=%0d exp=1", rx_q.size() - base); end
    else begin
      n_tests++; if (rx_q[base] !== {1'b0, expw}) begin n_fail++; $display("FAIL mid_start_word got=%h exp=%h", rx_q[base], {1'b0, expw}); end
    end
  endtask

  task automatic test_backpressure();
    int base, rs0;
    do_reset();
    base = rx_q.size();
    rs0  = resync_cnt;
    // Phase order: stall 16, drain 16, idle 1, stall 24 (overflow), then run to next frame.
    for (int i = 0; i < 16 + 16 + 1 + 24 + (H * V - 56) + 8 + 4; i++) begin
      if (i < 16)                     tick(1'b1, 1'b0, cur_lin());
      else if (i < 32)                tick(1'b1, 1'b1, cur_lin());
      else if (i == 32)               tick(1'b0, 1'b1, 16'd0);
      else if (i < 57)                tick(1'b1, 1'b0, cur_lin());
      else if (i < 57 + H * V - 56 + 8) tick(1'b1, 1'b1, cur_lin());
      else                            tick(1'b0, 1'b1, 16'd0);
      n_tests++;
      if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL backpressure_cycle t=%0t got=%h exp=%h", $time, dut_vec(), exp_vec()); end
      if (i == 15) begin
        n_tests++;
        if (overflow_out !== 1'b0 || write_axis_valid !== 1'b1) begin n_fail++; $display("FAIL bp_two_held got ovf=%b vld=%b exp ovf=0 vld=1", overflow_out, write_axis_valid); end
      end
      if (i == 56) begin
        n_tests++;
        if (overflow_out !== 1'b1 || resync_out !== 1'b1) begin n_fail++; $display("FAIL bp_overflow got ovf=%b resync=%b exp 1 1", overflow_out, resync_out); end
      end
    end
    n_tests++; if (overflow_out !== 1'b1) begin n_fail++; $display("FAIL bp_sticky got=%b exp=1", overflow_out); end
    n_tests++; if (resync_cnt - rs0 !== 1) begin n_fail++; $display("FAIL bp_resync_count got=%0d exp=1", resync_cnt - rs0); end
    n_tests++;
    if (rx_q.size() - base !== 7) begin n_fail++; $display("FAIL bp_count got=%0d exp=7", rx_q.size() - base); end
    else begin
      for (int k = 0; k < 6; k++) begin
        n_tests++;
        if (rx_q[base + k] !== lin_word(k, 1'b0)) begin n_fail++; $display("FAIL bp_word%0d got=%h exp=%h", k, rx_q[base + k], lin_word(k, 1'b0)); end
      end
      n_tests++;
      if (rx_q[base + 6] !== lin_word(0, 1'b0)) begin n_fail++; $display("FAIL bp_restart_word got=%h exp=%h", rx_q[base + 6], lin_word(0, 1'b0)); end
    end
  endtask

  task automatic test_sof_inject();
    int base, rs0, d0;
    do_reset();
    base = rx_q.size();
    rs0  = resync_cnt;
    d0   = done_cnt;
    for (int i = 0; i < 83 + H * V + 4; i++) begin
      if (i == 83) begin pos_h = 0; pos_v = 0; end
      if (i < 83 + H * V) tick(1'b1, 1'b1, cur_lin());
      else                tick(1'b0, 1'b1, 16'd0);
      n_tests++;
      if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL sof_inject_cycle t=%0t got=%h exp=%h", $time, dut_vec(), exp_vec()); end
    end
    n_tests++; if (resync_cnt - rs0 !== 1) begin n_fail++; $display("FAIL sof_inject_resync got=%0d exp=1", resync_cnt - rs0); end
    n_tests++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL sof_inject_done got=%0d exp=1", done_cnt - d0); end
    n_tests++;
    if (rx_q.size() - base !== 10 + FW) begin n_fail++; $display("FAIL sof_inject_count got=%0d exp=%0d", rx_q.size() - base, 10 + FW); end
    else begin
      for (int k = 0; k < 10 + FW; k++) begin
        n_tests++;
        if (k < 10 && rx_q[base + k] !== lin_word(k, 1'b0)) begin n_fail++; $display("FAIL sof_inject_old%0d got=%h exp=%h", k, rx_q[base + k], lin_word(k, 1'b0)); end
        if (k >= 10 && rx_q[base + k] !== lin_word(k - 10, (k - 10) == FW - 1)) begin n_fail++; $display("FAIL sof_inject_new%0d got=%h exp=%h", k - 10, rx_q[base + k], lin_word(k - 10, (k - 10) == FW - 1)); end
      end
    end
  endtask

  task automatic test_reset_midword();
    int base;
    do_reset();
    for (int i = 0; i < 19; i++) begin
      tick(1'b1, 1'b1, cur_lin());
      n_tests++;
      if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL rst_mid_pre_cycle t=%0t got=%h exp=%h", $time, dut_vec(), exp_vec()); end
    end
    rst_in = 1'b0;
    #1;
    n_tests++; if (write_axis_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got=%b exp=0", write_axis_valid); end
    n_tests++; if (write_axis_data !== 128'd0) begin n_fail++; $display("FAIL rst_mid_data got=%h exp=0", write_axis_data); end
    n_tests++; if ({write_axis_tlast, overflow_out, resync_out, frame_done_out} !== 4'b0) begin n_fail++; $display("FAIL rst_mid_flags got=%b exp=0000", {write_axis_tlast, overflow_out, resync_out, frame_done_out}); end
    tick(1'b1, 1'b1, cur_lin());
    rst_in = 1'b1;
    base = rx_q.size();
    for (int i = 0; i < (H * V - 20) + 8 + 4; i++) begin
      if (i < (H * V - 20) + 8) tick(1'b1, 1'b1, cur_lin());
      else                      tick(1'b0, 1'b1, 16'd0);
      n_tests++;
      if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL rst_mid_cycle t=%0t got=%h exp=%h", $time, dut_vec(), exp_vec()); end
    end
    n_tests++;
    if (rx_q.size() - base !== 1) begin n_fail++; $display("FAIL rst_mid_count got=%0d exp=1", rx_q.size() - base); end
    else begin
      n_tests++; if (rx_q[base] !== lin_word(0, 1'b0)) begin n_fail++; $display("FAIL rst_mid_realign got=%h exp=%h", rx_q[base], lin_word(0, 1'b0)); end
    end
  endtask

  task automatic test_random_ready();
    int base, d0, nfed, cyc, bad_tlast;
    bit pv, rdy, prev_v;
    logic [128:0] prev_w;
    do_reset();
    base = rx_q.size();
    d0   = done_cnt;
    nfed = 0;
    cyc  = 0;
    prev_v = 1'b0;
    prev_w = '0;
    while (nfed < 2 * FW * 8 && cyc < 4000) begin
      pv  = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      tick(pv, rdy, 16'($urandom));
      nfed += int'(pv);
      cyc++;
      n_tests++;
      if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL random_cycle t=%0t got=%h exp=%h", $time, dut_vec(), exp_vec()); end
      if (prev_v && !rdy) begin
        n_tests++;
        if (write_axis_valid !== 1'b1 || {write_axis_tlast, write_axis_data} !== prev_w) begin n_fail++; $display("FAIL random_stall_hold t=%0t got=%h exp=%h", $time, {write_axis_tlast, write_axis_data}, prev_w); end
      end
      prev_v = write_axis_valid;
      prev_w = {write_axis_tlast, write_axis_data};
    end
    n_tests++; if (nfed !== 2 * FW * 8) begin n_fail++; $display("FAIL random_budget got=%0d pixels exp=%0d", nfed, 2 * FW * 8); end
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 16'd0);
    n_tests++; if (rx_q.size() - base !== 2 * FW) begin n_fail++; $display("FAIL random_handshakes got=%0d exp=%0d", rx_q.size() - base, 2 * FW); end
    bad_tlast = 0;
    for (int k = 0; k < rx_q.size() - base; k++)
      if (rx_q[base + k][128] !== ((k % FW) == FW - 1)) bad_tlast++;
    n_tests++; if (bad_tlast !== 0) begin n_fail++; $display("FAIL random_tlast_positions got=%0d wrong exp=0", bad_tlast); end
    n_tests++; if (done_cnt - d0 !== 2) begin n_fail++; $display("FAIL random_frame_done got=%0d exp=2", done_cnt - d0); end
    n_tests++; if (overflow_out !== 1'b0) begin n_fail++; $display("FAIL random_overflow got=%b exp=0", overflow_out); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_mid_start();
    test_backpressure();
    test_sof_inject();
    test_reset_midword();
    test_random_ready();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
